// File: rtl/ch_stream_serializer_pkg.sv
// Shared definitions for the narrow-stream serializer/deserializer pair.
// Holds the beat geometry and the transmitter state encoding.
package ch_stream_serializer_pkg;

    localparam int BEAT_W = 4;
    localparam int BEATS  = 4;
    localparam int WORD_W = BEAT_W * BEATS;
    localparam int CNT_W  = $clog2(BEATS);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

endpackage

// File: rtl/ch_stream_serializer.sv
// Splits one wide word into BEATS narrow beats, LSB first, on a valid/ready output.
// A new word may be taken on the same cycle the last beat leaves, giving gap-free streaming.
module ch_stream_serializer
    import ch_stream_serializer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              io_in_valid,
    input  logic [WORD_W-1:0] io_in_data,
    output logic              io_in_ready,
    output logic              io_out_valid,
    output logic [BEAT_W-1:0] io_out_data,
    input  logic              io_out_ready,
    output logic              io_busy,
    output logic [CNT_W-1:0]  io_beat_idx
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [WORD_W-1:0] r_sh;
    logic [WORD_W-1:0] w_sh_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_last;

    assign w_last = (r_state == SEND) && (r_cnt == LAST_BEAT);

    // Output-side ready feeds straight through so the next word can be accepted with the last beat.
    assign io_in_ready  = (r_state == IDLE) | (w_last & io_out_ready);
    assign io_out_valid = (r_state == SEND);
    assign io_busy      = (r_state == SEND);
    assign io_out_data  = r_sh[BEAT_W-1:0];
    assign io_beat_idx  = r_cnt;

    // State, shift register and beat counter; reset drops any word in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_sh    <= {WORD_W{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_sh    <= w_sh_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: load on accept, shift on each beat, reload or go idle after the last beat.
    always_comb begin
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (io_in_valid) begin
                    w_state_nxt = SEND;
                    w_sh_nxt    = io_in_data;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SEND: begin
                if (!io_out_ready) begin
                    w_state_nxt = SEND;
                end else if (r_cnt != LAST_BEAT) begin
                    w_sh_nxt  = r_sh >> BEAT_W;
                    w_cnt_nxt = r_cnt + 1'b1;
                end else if (io_in_valid) begin
                    w_sh_nxt  = io_in_data;
                    w_cnt_nxt = {CNT_W{1'b0}};
                end else begin
                    w_state_nxt = IDLE;
                    w_sh_nxt    = {WORD_W{1'b0}};
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_sh_nxt    = {WORD_W{1'b0}};
                w_cnt_nxt   = {CNT_W{1'b0}};
            end
        endcase
    end

endmodule

// File: tb/tb_ch_stream_serializer.sv
// Directed bench for ch_stream_serializer: basic, backpressure, back-to-back,
// stalled last beat, mid-word reset, and a FIFO-sink system run.
module tb_ch_stream_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_in_valid;
    logic [15:0] io_in_data;
    logic        io_in_ready;
    logic        io_out_valid;
    logic [3:0]  io_out_data;
    logic        io_out_ready;
    logic        io_busy;
    logic [1:0]  io_beat_idx;

    int n_cmp = 0;
    int n_err = 0;

    ch_stream_serializer dut (
        .clk          (clk),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_data   (io_in_data),
        .io_in_ready  (io_in_ready),
        .io_out_valid (io_out_valid),
        .io_out_data  (io_out_data),
        .io_out_ready (io_out_ready),
        .io_busy      (io_busy),
        .io_beat_idx  (io_beat_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [3:0] d, input logic [1:0] idx,
                            input logic rdy);
        #1;
        chk({tag, "_valid"}, 16'(io_out_valid), 16'd1);
        chk({tag, "_data"},  16'(io_out_data),  16'(d));
        chk({tag, "_idx"},   16'(io_beat_idx),  16'(idx));
        chk({tag, "_inrdy"}, 16'(io_in_ready),  16'(rdy));
    endtask

    task automatic chk_idle(input string tag);
        #1;
        chk({tag, "_valid"}, 16'(io_out_valid), 16'd0);
        chk({tag, "_busy"},  16'(io_busy),      16'd0);
        chk({tag, "_data"},  16'(io_out_data),  16'd0);
        chk({tag, "_idx"},   16'(io_beat_idx),  16'd0);
        chk({tag, "_inrdy"}, 16'(io_in_ready),  16'd1);
    endtask

    logic [3:0]  b2b [8];
    logic [15:0] sys_words [6];
    logic [3:0]  fifo_q [$];
    logic [3:0]  exp_q  [$];
    logic [3:0]  got;
    logic [15:0] w;
    int          widx;
    int          cyc;

    initial begin
        reset = 1'b1; io_in_valid = 1'b0; io_in_data = 16'h0000; io_out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk_idle("rst");

        // Basic: 0xA5C3 -> 3,C,5,A
        io_in_valid = 1'b1; io_in_data = 16'hA5C3; io_out_ready = 1'b1;
        tick();
        io_in_valid = 1'b0; io_in_data = 16'hFFFF;
        chk_beat("bas0", 4'h3, 2'd0, 1'b0); tick();
        chk_beat("bas1", 4'hC, 2'd1, 1'b0); tick();
        chk_beat("bas2", 4'h5, 2'd2, 1'b0); tick();
        chk_beat("bas3", 4'hA, 2'd3, 1'b1); tick();
        chk_idle("bas_end");

        // Backpressure on beat 1 for three cycles
        io_in_valid = 1'b1; io_in_data = 16'hA5C3;
        tick();
        io_in_valid = 1'b0;
        chk_beat("bp0", 4'h3, 2'd0, 1'b0); tick();
        io_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_beat("bp_hold", 4'hC, 2'd1, 1'b0); tick();
        end
        io_out_ready = 1'b1;
        chk_beat("bp1", 4'hC, 2'd1, 1'b0); tick();
        chk_beat("bp2", 4'h5, 2'd2, 1'b0); tick();
        chk_beat("bp3", 4'hA, 2'd3, 1'b1); tick();
        chk_idle("bp_end");

        // Back-to-back 0x1234 then 0xBEEF
        b2b[0] = 4'h4; b2b[1] = 4'h3; b2b[2] = 4'h2; b2b[3] = 4'h1;
        b2b[4] = 4'hF; b2b[5] = 4'hE; b2b[6] = 4'hE; b2b[7] = 4'hB;
        io_in_valid = 1'b1; io_in_data = 16'h1234;
        tick();
        io_in_data = 16'hBEEF;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) io_in_valid = 1'b0;
            chk_beat("b2b", b2b[i], 2'(i % 4), (i % 4) == 3);
            tick();
        end
        chk_idle("b2b_end");

        // Last beat stalled with a word waiting
        io_in_valid = 1'b1; io_in_data = 16'h4321;
        tick();
        io_in_valid = 1'b0;
        tick(); tick(); tick();
        io_out_ready = 1'b0; io_in_valid = 1'b1; io_in_data = 16'h9876;
        chk_beat("stl_a", 4'h4, 2'd3, 1'b0); tick();
        chk_beat("stl_b", 4'h4, 2'd3, 1'b0);
        io_out_ready = 1'b1;
        chk_beat("stl_c", 4'h4, 2'd3, 1'b1); tick();
        io_in_valid = 1'b0;
        chk_beat("stl_n0", 4'h6, 2'd0, 1'b0); tick();
        chk_beat("stl_n1", 4'h7, 2'd1, 1'b0); tick();
        chk_beat("stl_n2", 4'h8, 2'd2, 1'b0); tick();
        chk_beat("stl_n3", 4'h9, 2'd3, 1'b1); tick();
        chk_idle("stl_end");

        // Reset while beat 1 of 0xA5C3 is presented
        io_in_valid = 1'b1; io_in_data = 16'hA5C3;
        tick();
        io_in_valid = 1'b0;
        tick();
        chk_beat("mr1", 4'hC, 2'd1, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle("mr_rst");
        io_in_valid = 1'b1; io_in_data = 16'h0F0F;
        tick();
        io_in_valid = 1'b0;
        chk_beat("mr_n0", 4'hF, 2'd0, 1'b0); tick();
        chk_beat("mr_n1", 4'h0, 2'd1, 1'b0); tick();
        chk_beat("mr_n2", 4'hF, 2'd2, 1'b0); tick();
        chk_beat("mr_n3", 4'h0, 2'd3, 1'b1); tick();
        chk_idle("mr_end");

        // System: 2-entry FIFO sink with random dequeue
        sys_words[0] = 16'h1357; sys_words[1] = 16'h2468; sys_words[2] = 16'hDEAD;
        sys_words[3] = 16'hC0DE; sys_words[4] = 16'h0001; sys_words[5] = 16'hF00F;
        widx = 0; cyc = 0;
        while (cyc < 600 && !(widx == 6 && exp_q.size() == 0)) begin
            io_in_valid  = (widx < 6);
            io_in_data   = (widx < 6) ? sys_words[widx] : 16'h0000;
            io_out_ready = (fifo_q.size() < 2);
            #1;
            if (fifo_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                got = fifo_q.pop_front();
                if (exp_q.size() == 0) begin
                    chk("sys_extra", 16'd1, 16'd0);
                end else begin
                    chk("sys_deq", 16'(got), 16'(exp_q.pop_front()));
                end
            end
            if (io_in_valid && io_in_ready) begin
                w = sys_words[widx];
                for (int k = 0; k < 4; k++) exp_q.push_back(w[4*k +: 4]);
                widx++;
            end
            if (io_out_valid && io_out_ready) fifo_q.push_back(io_out_data);
            tick();
            cyc++;
        end
        io_in_valid = 1'b0;
        chk("sys_words_sent", 16'(widx), 16'd6);
        chk("sys_left", 16'(exp_q.size()), 16'd0);
        chk("sys_fifo_left", 16'(fifo_q.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
